miner_nonce_dispatch: RTL
=========================

// Module: miner_nonce_dispatch
// PURPOSE
// - Parametrised successor to the single-core miner: splits a nonce range across NUM_LANES external SHA-256 lanes.
// - Checks each returned hash against a leading-zero difficulty and reports the first winning nonce.
// - Sits between the job source (host/UART front end) and the sha256 core instances.
// PARAMETERS
// - NUM_LANES  4    number of hashing lanes driven (1..16)
// - NONCE_W    32   nonce width in bits
// - HASH_W     256  hash width returned per lane
// - ZBITS_W    9    width of difficulty field (leading zero bits required, 0..HASH_W)
// PORTS
// - clock        in   1                  system clock, rising edge
// - reset        in   1                  asynchronous, active-high reset
// - job_valid    in   1                  job offered
// - job_ready    out  1                  block idle, job can be taken
// - job_start    in   NONCE_W            first nonce (inclusive)
// - job_end      in   NONCE_W            last nonce (inclusive); may be below job_start (wraps)
// - job_zeros    in   ZBITS_W            required leading zero bits of hash MSBs
// - abort        in   1                  cancel current job
// - lane_ready   in   NUM_LANES          lane i can accept a nonce
// - lane_start   out  NUM_LANES          1-cycle issue strobe per lane
// - lane_nonce   out  NUM_LANES*NONCE_W  nonce for lane i, slice [i*NONCE_W +: NONCE_W], held while in flight
// - lane_done    in   NUM_LANES          lane i result valid this cycle
// - lane_hash    in   NUM_LANES*HASH_W   hash from lane i, valid with lane_done[i]
// - found_valid  out  1                  1-cycle pulse: winning nonce reported
// - found_nonce  out  NONCE_W            winning nonce, held until next job accepted
// - found_lane   out  clog2(NUM_LANES)   lane that produced the win, held with found_nonce
// - exhausted    out  1                  1-cycle pulse: range done, no hit
// - busy         out  1                  high in any state except IDLE
// BEHAVIOUR
// - Reset: all outputs 0 except job_ready=1; state IDLE; all in-flight flags and counters cleared, at any time.
// - States:
//   - IDLE: job_ready=1; job_valid accepted at edge T -> RUN; next_nonce=job_start, last=job_end.
//   - RUN: issues nonces; first lane_start possible in cycle T+1.
//   - DRAIN: no issue; waits for all in-flight lanes.
//   - IDLE entered from DRAIN (report done) or directly when nothing is in flight.
// - Issue: at most one nonce per cycle, to the lowest-index lane with lane_ready=1 and not in flight.
//   - lane_start[i]=1 for that cycle; lane_nonce slice loaded; in-flight[i] set.
//   - The nonce equal to last is the final issue; afterwards no more issues (range_done).
// - Range arithmetic is modulo 2^NONCE_W: job_end<job_start wraps through all-ones to 0.
//   - job_end==job_start-1 covers the full space; job_end==job_start issues exactly one nonce.
// - Result: lane_done[i] is honoured only if in-flight[i]; in-flight[i] clears that cycle; lane_done on an idle lane is ignored.
//   - Hit: top job_zeros bits of lane_hash slice all 0; job_zeros=0 always hits; job_zeros>=HASH_W requires hash==0.
//   - Several hits in one cycle: lowest lane index wins, others discarded.
// - First hit in RUN: latch found_nonce/found_lane, stop issuing (same-cycle issue suppressed), go DRAIN.
//   - In DRAIN, later results are discarded.
//   - When in-flight is empty, pulse found_valid, then IDLE.
//   - No lanes in flight at hit: found_valid in the cycle after lane_done.
// - RUN with range_done and nothing in flight: pulse exhausted, then IDLE.
// - abort in RUN/DRAIN: stop issuing, discard pending hit, drain, return to IDLE with no pulse; abort in IDLE is ignored.
// - Hit and final result in the same cycle: found_valid, not exhausted.
// - job_valid is ignored outside IDLE.
// CONFIGURATION
// - MINER_HASH_COUNT_EN defined:
//   - Adds output hash_count [31:0]: +1 per honoured lane_done, including discarded results.
//   - Saturates at 32'hFFFFFFFF, cleared by reset and on job acceptance.
// - MINER_HASH_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// - NUM_LANES=4, all lanes ready, start=10, end=13, zeros=8, all hashes 0xFF..:
//   - lane_start 0..3 on consecutive cycles with nonces 10..13; exhausted pulses once; found_valid never.
// - Same job, lane 2 hash = 0x00FF..:
//   - found_valid after lanes 0,1,3 drain; found_nonce=12, found_lane=2.
// - Lanes 1 and 3 done in the same cycle, both hits:
//   - found_lane=1; exactly one found_valid.
// - start=32'hFFFFFFFE, end=1:
//   - issued nonces FFFFFFFE, FFFFFFFF, 0, 1 in order; then exhausted.
// - abort asserted mid-RUN with 2 lanes in flight:
//   - no further lane_start; IDLE after both lane_done; no found_valid/exhausted.
// - reset asserted mid-RUN:
//   - outputs zero immediately, job_ready=1; a stale lane_done after reset is ignored.

Source files
------------

// File: rtl/miner_nonce_dispatch.sv
// miner_nonce_dispatch: splits a nonce range across NUM_LANES external hash
// lanes, checks returned hashes against a leading-zero difficulty and reports
// the first winning nonce (lowest lane index wins on a tie).
// Optional feature macro: MINER_HASH_COUNT_EN adds o_hash_count, a saturating
// count of honoured lane results for the current job.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready for a job, nothing in flight
// ST_RUN   | issuing nonces to free lanes, checking results
// ST_DRAIN | hit latched or abort seen; no issue, waiting for lanes to finish
module miner_nonce_dispatch #(
  parameter int NUM_LANES = 4,
  parameter int NONCE_W   = 32,
  parameter int HASH_W    = 256,
  parameter int ZBITS_W   = 9,
  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_job_valid,
  output logic                           o_job_ready,
  input  logic [NONCE_W-1:0]             i_job_start,
  input  logic [NONCE_W-1:0]             i_job_end,
  input  logic [ZBITS_W-1:0]             i_job_zeros,
  input  logic                           i_abort,
  input  logic [NUM_LANES-1:0]           i_lane_ready,
  output logic [NUM_LANES-1:0]           o_lane_start,
  output logic [NUM_LANES*NONCE_W-1:0]   o_lane_nonce,
  input  logic [NUM_LANES-1:0]           i_lane_done,
  input  logic [NUM_LANES*HASH_W-1:0]    i_lane_hash,
  output logic                           o_found_valid,
  output logic [NONCE_W-1:0]             o_found_nonce,
  output logic [LANE_W-1:0]              o_found_lane,
  output logic                           o_exhausted,
`ifdef MINER_HASH_COUNT_EN
  output logic [31:0]                    o_hash_count,
`endif
  output logic                           o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t               r_state, w_state_nxt;
  logic [NONCE_W-1:0]   r_next_nonce;
  logic [NONCE_W-1:0]   r_last_nonce;
  logic                 r_range_done;
  logic [ZBITS_W-1:0]   r_zeros;
  logic [NUM_LANES-1:0] r_inflight;
  logic [NONCE_W-1:0]   r_lane_nonce [NUM_LANES];
  logic                 r_hit_pend;
  logic [NONCE_W-1:0]   r_found_nonce;
  logic [LANE_W-1:0]    r_found_lane;

  logic [NUM_LANES-1:0] w_honoured;
  logic [NUM_LANES-1:0] w_lane_hit;
  logic                 w_hit_any;
  logic [LANE_W-1:0]    w_hit_lane;
  logic [NUM_LANES-1:0] w_free;
  logic                 w_free_any;
  logic [LANE_W-1:0]    w_pick;
  logic [NUM_LANES-1:0] w_issue_vec;
  logic                 w_issue;
  logic                 w_accept;
  logic                 w_latch_hit;
  logic                 w_clear_hit;

  // True when the top z bits of h are zero; z >= HASH_W demands an all-zero hash.
  function automatic logic f_zeros_ok(input logic [HASH_W-1:0] h, input logic [ZBITS_W-1:0] z);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < HASH_W; b++) begin
      if (((HASH_W - 1 - b) < int'(z)) && h[b]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Result qualification: only lanes we are waiting on count; pick lowest winner.
  always_comb begin
    w_honoured = i_lane_done & r_inflight;
    w_lane_hit = '0;
    w_hit_lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_lane_hit[i] = w_honoured[i] && f_zeros_ok(i_lane_hash[i*HASH_W +: HASH_W], r_zeros);
    end
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_lane_hit[i]) w_hit_lane = LANE_W'(i);
    end
    w_hit_any = |w_lane_hit;
  end

  // Issue target: lowest-index lane that is ready and not already busy for us.
  always_comb begin
    w_free     = i_lane_ready & ~r_inflight;
    w_free_any = |w_free;
    w_pick     = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_free[i]) w_pick = LANE_W'(i);
    end
    w_issue_vec = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_issue_vec[i] = w_issue && (w_pick == LANE_W'(i));
    end
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and control strobes; abort outranks a same-cycle hit.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_issue       = 1'b0;
    w_latch_hit   = 1'b0;
    w_clear_hit   = 1'b0;
    o_found_valid = 1'b0;
    o_exhausted   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_job_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_clear_hit = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (w_hit_any) begin
          w_latch_hit = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else if (r_range_done && (r_inflight == '0)) begin
          o_exhausted = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!r_range_done && w_free_any) begin
          w_issue = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (i_abort) w_clear_hit = 1'b1;
        if (r_inflight == '0) begin
          o_found_valid = r_hit_pend && !i_abort;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Job, range, in-flight and winner bookkeeping.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_next_nonce  <= '0;
      r_last_nonce  <= '0;
      r_range_done  <= 1'b0;
      r_zeros       <= '0;
      r_inflight    <= '0;
      r_hit_pend    <= 1'b0;
      r_found_nonce <= '0;
      r_found_lane  <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_lane_nonce[i] <= '0;
    end else begin
      r_inflight <= (r_inflight & ~w_honoured) | w_issue_vec;
      if (w_accept) begin
        r_next_nonce  <= i_job_start;
        r_last_nonce  <= i_job_end;
        r_zeros       <= i_job_zeros;
        r_range_done  <= 1'b0;
        r_hit_pend    <= 1'b0;
        r_found_nonce <= '0;
        r_found_lane  <= '0;
      end
      if (w_issue) begin
        r_lane_nonce[w_pick] <= r_next_nonce;
        if (r_next_nonce == r_last_nonce) r_range_done <= 1'b1;
        else                              r_next_nonce <= r_next_nonce + 1'b1;
      end
      if (w_latch_hit) begin
        r_hit_pend    <= 1'b1;
        r_found_nonce <= r_lane_nonce[w_hit_lane];
        r_found_lane  <= w_hit_lane;
      end
      if (w_clear_hit) r_hit_pend <= 1'b0;
    end
  end

`ifdef MINER_HASH_COUNT_EN
  logic [31:0] r_hash_count;
  logic [32:0] w_count_sum;

  // Saturating sum of honoured results, discarded ones included.
  always_comb begin
    w_count_sum = {1'b0, r_hash_count};
    for (int i = 0; i < NUM_LANES; i++) begin
      w_count_sum = w_count_sum + {32'd0, w_honoured[i]};
    end
  end

  // Hash counter register, restarted on each accepted job.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)          r_hash_count <= '0;
    else if (w_accept)    r_hash_count <= '0;
    else if (w_count_sum[32]) r_hash_count <= 32'hFFFF_FFFF;
    else                  r_hash_count <= w_count_sum[31:0];
  end

  assign o_hash_count = r_hash_count;
`endif

  genvar g;
  for (g = 0; g < NUM_LANES; g++) begin : g_nonce_out
    assign o_lane_nonce[g*NONCE_W +: NONCE_W] = r_lane_nonce[g];
  end

  assign o_lane_start  = w_issue_vec;
  assign o_job_ready   = (r_state == ST_IDLE);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_found_nonce = r_found_nonce;
  assign o_found_lane  = r_found_lane;

endmodule
